// File: rtl/fb_scanout_reader_pkg.sv
// Shared raster timing defaults, sync window helper and decoded raster flags
// for the framebuffer scanout path.
package fb_scanout_reader_pkg;

  localparam int PIX_DIV_DEF  = 5;
  localparam int MEM_LAT_DEF  = 1;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  localparam int CNT_W = 10;

  typedef struct packed {
    logic act;
    logic hsync_n;
    logic vsync_n;
    logic origin;
  } raster_flags_t;

  // Half-open window test [lo, hi) on a raster coordinate.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
    int unsigned p;
    p = {{(32-CNT_W){1'b0}}, pos};
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/fb_scanout_reader_timing.sv
// video_timing_gen: pixel divider, h/v raster counters and per-position
// decode (active area, sync windows, origin).
module video_timing_gen
  import fb_scanout_reader_pkg::*;
#(
  parameter int PIX_DIV  = PIX_DIV_DEF,
  parameter int DIV_W    = 3,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             run,
  output logic [DIV_W-1:0] div,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             pix_tick,
  output raster_flags_t    flags
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic             run_reg;
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] h_reg;
  logic [CNT_W-1:0] v_reg;
  logic             last_div;

  assign last_div = (div_reg == DIV_W'(PIX_DIV - 1));

  // run_reg delays counting by one clk so the first running period starts at div=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
      div_reg <= '0;
      h_reg   <= '0;
      v_reg   <= '0;
    end else if (!en) begin
      run_reg <= 1'b0;
      div_reg <= '0;
      h_reg   <= '0;
      v_reg   <= '0;
    end else begin
      run_reg <= 1'b1;
      if (run_reg) begin
        if (last_div) begin
          div_reg <= '0;
          if (h_reg == CNT_W'(H_TOTAL - 1)) begin
            h_reg <= '0;
            v_reg <= (v_reg == CNT_W'(V_TOTAL - 1)) ? '0 : v_reg + 1'b1;
          end else begin
            h_reg <= h_reg + 1'b1;
          end
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end
    end
  end

  assign run           = run_reg;
  assign div           = div_reg;
  assign h             = h_reg;
  assign v             = v_reg;
  assign pix_tick      = run_reg && last_div;
  assign flags.act     = (h_reg < CNT_W'(H_ACTIVE)) && (v_reg < CNT_W'(V_ACTIVE));
  assign flags.hsync_n = !in_window(h_reg, HS_START, HS_END);
  assign flags.vsync_n = !in_window(v_reg, VS_START, VS_END);
  assign flags.origin  = (h_reg == '0) && (v_reg == '0);

endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout: fetches one bit per visible pixel, captures it after the
// memory latency and presents pix/DE/syncs one pixel period after the fetch.
module fb_scanout_reader
  import fb_scanout_reader_pkg::*;
#(
  parameter int PIX_DIV  = PIX_DIV_DEF,
  parameter int MEM_LAT  = MEM_LAT_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rd_en,
  output logic [CNT_W-1:0] rd_x,
  output logic [CNT_W-1:0] rd_y,
  input  logic             rd_data,
  output logic             pix_tick,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             pix,
  output logic             frame_start
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  if (MEM_LAT < 1 || MEM_LAT > PIX_DIV - 2) begin : g_bad_mem_lat
    $error("fb_scanout_reader: MEM_LAT=%0d outside 1..PIX_DIV-2 (PIX_DIV=%0d)",
           MEM_LAT, PIX_DIV);
  end

  logic             run;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             tick;
  raster_flags_t    flags;

  video_timing_gen #(
    .PIX_DIV  (PIX_DIV),
    .DIV_W    (DIV_W),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .run      (run),
    .div      (div),
    .h        (h),
    .v        (v),
    .pix_tick (tick),
    .flags    (flags)
  );

  logic             fetch;
  logic             capture;
  logic [CNT_W-1:0] rd_x_reg;
  logic [CNT_W-1:0] rd_y_reg;
  logic             pix_q_reg;
  logic             de_reg;
  logic             pix_reg;
  logic             hsync_reg;
  logic             vsync_reg;
  logic             frame_start_reg;

  assign fetch   = run && (div == '0) && flags.act;
  assign capture = run && (div == DIV_W'(MEM_LAT));

  // h/v are constant across a pixel period, so act at capture time tells
  // whether this period issued a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x_reg        <= '0;
      rd_y_reg        <= '0;
      pix_q_reg       <= 1'b0;
      de_reg          <= 1'b0;
      pix_reg         <= 1'b0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
    end else if (!en) begin
      rd_x_reg        <= '0;
      rd_y_reg        <= '0;
      pix_q_reg       <= 1'b0;
      de_reg          <= 1'b0;
      pix_reg         <= 1'b0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      if (fetch) begin
        rd_x_reg <= h;
        rd_y_reg <= v;
      end
      if (capture) begin
        pix_q_reg <= flags.act & rd_data;
      end
      frame_start_reg <= tick && flags.origin;
      if (tick) begin
        de_reg    <= flags.act;
        pix_reg   <= pix_q_reg & flags.act;
        hsync_reg <= flags.hsync_n;
        vsync_reg <= flags.vsync_n;
      end
    end
  end

  assign rd_en       = fetch;
  assign rd_x        = fetch ? h : rd_x_reg;
  assign rd_y        = fetch ? v : rd_y_reg;
  assign pix_tick    = tick;
  assign de          = de_reg;
  assign pix         = pix_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Randomized bench for fb_scanout_reader: a reduced raster, two builds
// (MEM_LAT 1 and 3) and a cycle-indexed reference model of the raster.
module tb_fb_scanout_reader;

  localparam int P    = 5;
  localparam int HA   = 8;
  localparam int HFP  = 2;
  localparam int HSW  = 3;
  localparam int HBP  = 2;
  localparam int VA   = 6;
  localparam int VFP  = 1;
  localparam int VSW  = 2;
  localparam int VBP  = 1;
  localparam int HT   = HA + HFP + HSW + HBP;
  localparam int VT   = VA + VFP + VSW + VBP;
  localparam int NCYC = 9000;

  typedef struct {
    bit rd_en;
    int rd_x;
    int rd_y;
    bit tick;
    bit de;
    bit pix;
    bit hs;
    bit vs;
    bit fs;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rd_en1, rd_en3;
  logic [9:0] rd_x1, rd_y1, rd_x3, rd_y3;
  logic       rd_data1, rd_data3;
  logic       tick1, de1, hs1, vs1, pix1, fs1;
  logic       tick3, de3, hs3, vs3, pix3, fs3;

  bit         mem [0:VA-1][0:HA-1];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         model_n = -1;
  int         last_x = 0;
  int         last_y = 0;
  int         frames = 0;

  fb_scanout_reader #(
    .PIX_DIV(P), .MEM_LAT(1),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .rd_en(rd_en1), .rd_x(rd_x1), .rd_y(rd_y1), .rd_data(rd_data1),
    .pix_tick(tick1), .de(de1), .hsync(hs1), .vsync(vs1), .pix(pix1),
    .frame_start(fs1)
  );

  fb_scanout_reader #(
    .PIX_DIV(P), .MEM_LAT(3),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .rd_en(rd_en3), .rd_x(rd_x3), .rd_y(rd_y3), .rd_data(rd_data3),
    .pix_tick(tick3), .de(de3), .hsync(hs3), .vsync(vs3), .pix(pix3),
    .frame_start(fs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: valid data exactly LAT clks after rd_en, random noise otherwise.
  always @(posedge clk) begin
    if (rd_en1 === 1'b1) rd_data1 <= mem[rd_y1][rd_x1];
    else                 rd_data1 <= 1'($urandom_range(0, 1));
  end

  bit       h3_v [0:2];
  int       h3_x [0:2];
  int       h3_y [0:2];
  always @(posedge clk) begin
    for (int i = 2; i > 0; i--) begin
      h3_v[i] = h3_v[i-1];
      h3_x[i] = h3_x[i-1];
      h3_y[i] = h3_y[i-1];
    end
    h3_v[0] = (rd_en3 === 1'b1);
    h3_x[0] = int'(rd_x3);
    h3_y[0] = int'(rd_y3);
    if (h3_v[2]) rd_data3 <= mem[h3_y[2]][h3_x[2]];
    else         rd_data3 <= 1'($urandom_range(0, 1));
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs for the clk that is cycle n of an uninterrupted run (n<0: idle).
  task automatic compute_exp(input int n, output exp_t e);
    int k, d, h, v, jh, jv;
    bit jact;
    e = '{rd_en: 0, rd_x: 0, rd_y: 0, tick: 0, de: 0, pix: 0, hs: 1, vs: 1, fs: 0};
    if (n < 0) begin
      last_x = 0;
      last_y = 0;
      return;
    end
    k = n / P;
    d = n % P;
    h = k % HT;
    v = (k / HT) % VT;
    e.tick = (d == P - 1);
    if (d == 0 && h < HA && v < VA) begin
      e.rd_en = 1;
      last_x  = h;
      last_y  = v;
    end
    e.rd_x = last_x;
    e.rd_y = last_y;
    if (k > 0) begin
      jh   = (k - 1) % HT;
      jv   = ((k - 1) / HT) % VT;
      jact = (jh < HA) && (jv < VA);
      e.de  = jact;
      e.pix = jact ? mem[jv][jh] : 1'b0;
      e.hs  = !(jh >= HA + HFP && jh < HA + HFP + HSW);
      e.vs  = !(jv >= VA + VFP && jv < VA + VFP + VSW);
      e.fs  = (d == 0) && (jh == 0) && (jv == 0);
    end
  endtask

  task automatic check_dut(input string who, input exp_t e,
                           input logic g_rd_en, input logic [9:0] g_x,
                           input logic [9:0] g_y, input logic g_tick,
                           input logic g_de, input logic g_pix,
                           input logic g_hs, input logic g_vs, input logic g_fs);
    check_val({who, ".rd_en"},       int'(g_rd_en), int'(e.rd_en));
    check_val({who, ".rd_x"},        int'(g_x),     e.rd_x);
    check_val({who, ".rd_y"},        int'(g_y),     e.rd_y);
    check_val({who, ".pix_tick"},    int'(g_tick),  int'(e.tick));
    check_val({who, ".de"},          int'(g_de),    int'(e.de));
    check_val({who, ".pix"},         int'(g_pix),   int'(e.pix));
    check_val({who, ".hsync"},       int'(g_hs),    int'(e.hs));
    check_val({who, ".vsync"},       int'(g_vs),    int'(e.vs));
    check_val({who, ".frame_start"}, int'(g_fs),    int'(e.fs));
  endtask

  task automatic check_both(input int n);
    exp_t e;
    compute_exp(n, e);
    check_dut("lat1", e, rd_en1, rd_x1, rd_y1, tick1, de1, pix1, hs1, vs1, fs1);
    check_dut("lat3", e, rd_en3, rd_x3, rd_y3, tick3, de3, pix3, hs3, vs3, fs3);
    if (e.fs) begin
      frames++;
      $display("frame %0d started at cycle %0d", frames, cyc);
    end
  endtask

  initial begin
    int rst_cnt;
    int off_cnt;
    int r;
    rst_cnt = 0;
    off_cnt = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        mem[y][x] = (y < 2) ? bit'((x ^ y) & 1) : 1'($urandom_range(0, 1));

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_both(model_n);

      if (cyc < 4) begin
        rst_n = 1'b0;
        en    = 1'b0;
      end else if (cyc < 6) begin
        rst_n = 1'b1;
        en    = 1'b0;
      end else if (cyc < 2600) begin
        rst_n = 1'b1;
        en    = 1'b1;
      end else begin
        if (rst_cnt == 0 && off_cnt == 0) begin
          r = int'($urandom_range(0, 599));
          if (r == 0) begin
            rst_cnt = int'($urandom_range(1, 3));
            $display("reset pulse of %0d clks at cycle %0d", rst_cnt, cyc);
          end else if (r == 1) begin
            off_cnt = int'($urandom_range(1, 4));
            $display("en low for %0d clks at cycle %0d", off_cnt, cyc);
          end
        end
        if (rst_cnt > 0) begin
          rst_cnt--;
          rst_n = 1'b0;
          en    = 1'($urandom_range(0, 1));
        end else if (off_cnt > 0) begin
          off_cnt--;
          rst_n = 1'b1;
          en    = 1'b0;
        end else begin
          rst_n = 1'b1;
          en    = 1'b1;
        end
      end

      // Reset is asynchronous: outputs must already be idle before the next edge.
      #1;
      if (!rst_n) check_both(-1);

      if (!rst_n || !en) model_n = -1;
      else               model_n = model_n + 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
